// File: rtl/segre_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : segre_pkg
//  Description : Shared widths, width helpers and types for the
//                set-associative tag store.
//  Revision    : 1.0 - initial release
// ============================================================================
package segre_pkg;

  // Width helpers, usable in parameter expressions of any instantiation.
  function automatic int calc_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_way_w(input int num_ways);
    return $clog2(num_ways);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int num_sets,
                                    input int line_bytes);
    return addr_width - $clog2(num_sets) - $clog2(line_bytes);
  endfunction

  // Default geometry.
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_NUM_SETS   = 8;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int DEF_LINE_BYTES = 16;

  localparam int DEF_OFF_W = calc_off_w(DEF_LINE_BYTES);
  localparam int DEF_IDX_W = calc_idx_w(DEF_NUM_SETS);
  localparam int DEF_WAY_W = calc_way_w(DEF_NUM_WAYS);
  localparam int DEF_TAG_W = calc_tag_w(DEF_ADDR_WIDTH, DEF_NUM_SETS, DEF_LINE_BYTES);

  typedef logic [DEF_TAG_W-1:0]    tag_t;
  typedef logic [DEF_IDX_W-1:0]    idx_t;
  typedef logic [DEF_WAY_W-1:0]    way_t;
  typedef logic [DEF_NUM_WAYS-2:0] plru_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage
`default_nettype wire

// File: rtl/segre_cache_tags_assoc_if.sv
`default_nettype none
// ============================================================================
//  Module      : segre_cache_tags_assoc_if
//  Description : Lookup / fill / invalidate / flush bundle of the tag store.
//                slave is the tag store side, master the controller side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface segre_cache_tags_assoc_if
  import segre_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) ();

  localparam int TAG_W = calc_tag_w(ADDR_WIDTH, NUM_SETS, LINE_BYTES);
  localparam int WAY_W = calc_way_w(NUM_WAYS);

  logic [ADDR_WIDTH-1:0] lookup_addr_i;
  logic                  lookup_valid_i;
  logic                  hit_o;
  logic [WAY_W-1:0]      hit_way_o;
  logic [WAY_W-1:0]      victim_way_o;
  logic                  victim_valid_o;
  logic [TAG_W-1:0]      victim_tag_o;
  logic                  fill_en_i;
  logic [ADDR_WIDTH-1:0] fill_addr_i;
  logic [WAY_W-1:0]      fill_way_i;
  logic                  inv_en_i;
  logic [ADDR_WIDTH-1:0] inv_addr_i;
  logic                  flush_i;
  logic                  flush_busy_o;

  modport slave (
    input  lookup_addr_i, lookup_valid_i, fill_en_i, fill_addr_i, fill_way_i,
           inv_en_i, inv_addr_i, flush_i,
    output hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_tag_o,
           flush_busy_o
  );

  modport master (
    output lookup_addr_i, lookup_valid_i, fill_en_i, fill_addr_i, fill_way_i,
           inv_en_i, inv_addr_i, flush_i,
    input  hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_tag_o,
           flush_busy_o
  );

endinterface
`default_nettype wire

// File: rtl/segre_plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : segre_plru_tree
//  Description : Combinational tree pseudo-LRU for one set. Node n has
//                children 2n+1 (lower half) and 2n+2 (upper half); a node
//                bit of 0 points the victim into the lower half.
//  Revision    : 1.0 - initial release
// ============================================================================
module segre_plru_tree
  import segre_pkg::*;
#(
  parameter  int NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_W    = calc_way_w(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] plru_i,
  input  logic [WAY_W-1:0]    access_way_i,
  output logic [WAY_W-1:0]    victim_way_o,
  output logic [NUM_WAYS-2:0] plru_nxt_o
);

  int   w_vic_node;
  logic w_vic_bit;
  int   w_upd_node;
  logic w_upd_bit;

  // Follow each node's pointer from the root; the bits taken form the victim way.
  always_comb begin
    victim_way_o = '0;
    w_vic_node   = 0;
    w_vic_bit    = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      w_vic_bit = 1'b0;
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        if (n == w_vic_node) w_vic_bit = plru_i[n];
      end
      victim_way_o[WAY_W-1-lvl] = w_vic_bit;
      w_vic_node = 2 * w_vic_node + 1 + int'(w_vic_bit);
    end
  end

  // Along the accessed way's path, point every node at the other half.
  always_comb begin
    plru_nxt_o = plru_i;
    w_upd_node = 0;
    w_upd_bit  = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      w_upd_bit = access_way_i[WAY_W-1-lvl];
      for (int n = 0; n < NUM_WAYS - 1; n++) begin
        if (n == w_upd_node) plru_nxt_o[n] = ~w_upd_bit;
      end
      w_upd_node = 2 * w_upd_node + 1 + int'(w_upd_bit);
    end
  end

endmodule
`default_nettype wire

// File: rtl/segre_cache_tags_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : segre_cache_tags_assoc
//  Description : N-way set-associative tag store with per-line valid bits,
//                tree pseudo-LRU replacement, single-line invalidate and a
//                one-set-per-cycle flush-all sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module segre_cache_tags_assoc
  import segre_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                     clk_i,
  input  logic                     rsn_i,
  segre_cache_tags_assoc_if.slave  bus
);

  localparam int OFF_W  = calc_off_w(LINE_BYTES);
  localparam int IDX_W  = calc_idx_w(NUM_SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_WIDTH, NUM_SETS, LINE_BYTES);
  localparam int WAY_W  = calc_way_w(NUM_WAYS);
  localparam int PLRU_W = NUM_WAYS - 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  // Storage, indexed by set.
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [PLRU_W-1:0]   r_plru  [NUM_SETS];

  flush_state_e     r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_busy;

  // Address fields.
  logic [IDX_W-1:0] w_lk_idx, w_fill_idx, w_inv_idx;
  logic [TAG_W-1:0] w_lk_tag, w_fill_tag, w_inv_tag;

  assign w_lk_idx   = bus.lookup_addr_i[OFF_W +: IDX_W];
  assign w_lk_tag   = bus.lookup_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign w_fill_idx = bus.fill_addr_i[OFF_W +: IDX_W];
  assign w_fill_tag = bus.fill_addr_i[ADDR_WIDTH-1 -: TAG_W];
  assign w_inv_idx  = bus.inv_addr_i[OFF_W +: IDX_W];
  assign w_inv_tag  = bus.inv_addr_i[ADDR_WIDTH-1 -: TAG_W];

  logic             w_lk_match, w_inv_match, w_has_free;
  logic [WAY_W-1:0] w_lk_way, w_inv_way, w_free_way, w_victim_way;
  logic [WAY_W-1:0] w_plru_victim, w_fill_victim_unused;
  logic [PLRU_W-1:0] w_lk_plru_nxt, w_fill_plru_nxt;

  // Lookup tag compare; scanning downward leaves the lowest matching way.
  always_comb begin
    w_lk_match = 1'b0;
    w_lk_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
        w_lk_match = 1'b1;
        w_lk_way   = WAY_W'(w);
      end
    end
  end

  // Invalidate tag compare in the invalidate set.
  always_comb begin
    w_inv_match = 1'b0;
    w_inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_inv_idx][w] && (r_tag[w_inv_idx][w] == w_inv_tag)) begin
        w_inv_match = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
  end

  // Lowest-index empty way in the lookup set takes priority over PLRU.
  always_comb begin
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_lk_idx][w]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  segre_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_lookup (
    .plru_i       (r_plru[w_lk_idx]),
    .access_way_i (w_lk_way),
    .victim_way_o (w_plru_victim),
    .plru_nxt_o   (w_lk_plru_nxt)
  );

  segre_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_fill (
    .plru_i       (r_plru[w_fill_idx]),
    .access_way_i (bus.fill_way_i),
    .victim_way_o (w_fill_victim_unused),
    .plru_nxt_o   (w_fill_plru_nxt)
  );

  assign w_busy       = (r_state == FLUSH);
  assign w_victim_way = w_has_free ? w_free_way : w_plru_victim;

  assign bus.hit_o          = w_lk_match & ~w_busy;
  assign bus.hit_way_o      = bus.hit_o ? w_lk_way : '0;
  assign bus.victim_way_o   = w_victim_way;
  assign bus.victim_valid_o = ~w_has_free & ~w_busy;
  assign bus.victim_tag_o   = r_tag[w_lk_idx][w_victim_way];
  assign bus.flush_busy_o   = w_busy;

  // Line-offset bits never take part in tag/index decoding.
  logic w_unused;
  assign w_unused = ^{bus.lookup_addr_i[OFF_W-1:0], bus.fill_addr_i[OFF_W-1:0],
                      bus.inv_addr_i[OFF_W-1:0], w_fill_victim_unused};

  // Flush sequencer state and set counter.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Walk every set exactly once per flush, then return to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.flush_i) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        if (r_cnt == LAST_SET) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Array update: flush clears one set per cycle and blocks everything else;
  // otherwise invalidate, lookup MRU, then fill, so the fill's writes win.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          r_tag[s][w] <= '0;
        end
      end
    end else if (w_busy) begin
      r_valid[r_cnt] <= '0;
      r_plru[r_cnt]  <= '0;
    end else begin
      if (bus.inv_en_i && w_inv_match) begin
        r_valid[w_inv_idx][w_inv_way] <= 1'b0;
      end
      if (bus.lookup_valid_i && w_lk_match) begin
        r_plru[w_lk_idx] <= w_lk_plru_nxt;
      end
      if (bus.fill_en_i) begin
        r_tag[w_fill_idx][bus.fill_way_i]   <= w_fill_tag;
        r_valid[w_fill_idx][bus.fill_way_i] <= 1'b1;
        r_plru[w_fill_idx]                  <= w_fill_plru_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segre_cache_tags_assoc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_segre_cache_tags_assoc
//  Description : Directed scoreboard bench for the set-associative tag store
//                (8 sets, 4 ways, 16-byte lines).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_segre_cache_tags_assoc;

  logic clk = 1'b0;
  logic rsn = 1'b0;

  always #5 clk = ~clk;

  segre_cache_tags_assoc_if bus ();

  segre_cache_tags_assoc dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic [1:0]  hit_way;
    logic [1:0]  vic_way;
    logic        vic_valid;
    logic [24:0] vic_tag;
    logic        busy;
    bit          chk_way;
    bit          chk_tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Address with the given tag in the given set, offset 0.
  function automatic logic [31:0] mk(input logic [24:0] tag, input logic [2:0] set);
    return {tag, set, 4'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic h, input logic [1:0] hw,
                      input logic [1:0] vw, input logic vv, input logic [24:0] vt,
                      input logic b, input bit cw, input bit ct);
    exp_t e;
    e.name = n; e.hit = h; e.hit_way = hw; e.vic_way = vw; e.vic_valid = vv;
    e.vic_tag = vt; e.busy = b; e.chk_way = cw; e.chk_tag = ct;
    exp_q.push_back(e);
  endtask

  task automatic look(input logic [31:0] a, input logic lv, input string n,
                      input logic h, input logic [1:0] hw, input logic [1:0] vw,
                      input logic vv, input logic [24:0] vt, input bit cw, input bit ct);
    bus.lookup_addr_i  = a;
    bus.lookup_valid_i = lv;
    push(n, h, hw, vw, vv, vt, 1'b0, cw, ct);
    cyc();
    bus.lookup_valid_i = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] a, input logic [1:0] w);
    bus.fill_en_i   = 1'b1;
    bus.fill_addr_i = a;
    bus.fill_way_i  = w;
    cyc();
    bus.fill_en_i   = 1'b0;
  endtask

  // Monitor: compare the outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (bus.hit_o !== mon_e.hit || bus.hit_way_o !== mon_e.hit_way ||
          bus.victim_valid_o !== mon_e.vic_valid || bus.flush_busy_o !== mon_e.busy ||
          (mon_e.chk_way && bus.victim_way_o !== mon_e.vic_way) ||
          (mon_e.chk_tag && bus.victim_tag_o !== mon_e.vic_tag)) begin
        errors++;
        $display("FAIL %s: got hit=%0b way=%0d vic=%0d vv=%0b vtag=%h busy=%0b, want hit=%0b way=%0d vic=%0d vv=%0b vtag=%h busy=%0b (vic chk %0b, tag chk %0b)",
                 mon_e.name, bus.hit_o, bus.hit_way_o, bus.victim_way_o, bus.victim_valid_o,
                 bus.victim_tag_o, bus.flush_busy_o, mon_e.hit, mon_e.hit_way, mon_e.vic_way,
                 mon_e.vic_valid, mon_e.vic_tag, mon_e.busy, mon_e.chk_way, mon_e.chk_tag);
      end
    end
  end

  initial begin
    bus.lookup_addr_i  = '0;
    bus.lookup_valid_i = 1'b0;
    bus.fill_en_i      = 1'b0;
    bus.fill_addr_i    = '0;
    bus.fill_way_i     = '0;
    bus.inv_en_i       = 1'b0;
    bus.inv_addr_i     = '0;
    bus.flush_i        = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then first fill of 0x1230 (set 3, tag 0x24) into way 2.
    look(mk(25'h24, 3'd3), 1'b0, "in_reset", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);
    rsn = 1'b1;
    look(mk(25'h24, 3'd3), 1'b0, "after_reset", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);
    do_fill(32'h0000_1230, 2'd2);
    look(32'h0000_1230, 1'b0, "fill_hit", 1'b1, 2'd2, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);

    // Fill all four ways of set 3; PLRU then points at way 0.
    for (int w = 0; w < 4; w++) do_fill(mk(25'h100 + 25'(w), 3'd3), 2'(w));
    look(mk(25'h100, 3'd3), 1'b0, "full_set", 1'b1, 2'd0, 2'd0, 1'b1, 25'h100, 1'b1, 1'b1);
    look(mk(25'h100, 3'd3), 1'b1, "hit_way0", 1'b1, 2'd0, 2'd0, 1'b1, 25'h100, 1'b1, 1'b1);
    look(mk(25'h103, 3'd3), 1'b0, "plru_after_hit", 1'b1, 2'd3, 2'd2, 1'b1, 25'h102, 1'b1, 1'b1);
    look(mk(25'h555, 3'd3), 1'b0, "miss_set3", 1'b0, 2'd0, 2'd2, 1'b1, 25'h102, 1'b1, 1'b1);

    // Fill and invalidate on the same way: the fill wins.
    bus.fill_en_i = 1'b1; bus.fill_addr_i = mk(25'h201, 3'd3); bus.fill_way_i = 2'd1;
    bus.inv_en_i  = 1'b1; bus.inv_addr_i  = mk(25'h101, 3'd3);
    cyc();
    bus.fill_en_i = 1'b0; bus.inv_en_i = 1'b0;
    look(mk(25'h201, 3'd3), 1'b0, "fill_beats_inv", 1'b1, 2'd1, 2'd2, 1'b1, 25'h102, 1'b1, 1'b1);
    look(mk(25'h101, 3'd3), 1'b0, "old_tag_gone", 1'b0, 2'd0, 2'd2, 1'b1, 25'h102, 1'b1, 1'b1);

    // Invalidate way 3; it becomes the lowest free way.
    bus.inv_en_i = 1'b1; bus.inv_addr_i = mk(25'h103, 3'd3);
    cyc();
    bus.inv_en_i = 1'b0;
    look(mk(25'h103, 3'd3), 1'b0, "inv_way3", 1'b0, 2'd0, 2'd3, 1'b0, 25'h103, 1'b1, 1'b1);

    // Lookup hit and fill in the same set, same cycle: fill MRU wins.
    bus.fill_en_i = 1'b1; bus.fill_addr_i = mk(25'h303, 3'd3); bus.fill_way_i = 2'd3;
    look(mk(25'h100, 3'd3), 1'b1, "lv_with_fill", 1'b1, 2'd0, 2'd3, 1'b0, 25'h103, 1'b1, 1'b1);
    bus.fill_en_i = 1'b0;
    look(mk(25'h303, 3'd3), 1'b0, "fill_mru_wins", 1'b1, 2'd3, 2'd0, 1'b1, 25'h100, 1'b1, 1'b1);

    // Flush-all: busy for exactly eight cycles, inputs ignored meanwhile.
    for (int s = 0; s < 8; s++) do_fill(mk(25'h40 + 25'(s), 3'(s)), 2'd0);
    look(mk(25'h45, 3'd5), 1'b0, "pre_flush", 1'b1, 2'd0, 2'd1, 1'b0, 25'h0, 1'b1, 1'b1);
    bus.flush_i = 1'b1;
    look(mk(25'h45, 3'd5), 1'b0, "flush_start", 1'b1, 2'd0, 2'd1, 1'b0, 25'h0, 1'b1, 1'b1);
    bus.flush_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.fill_en_i = 1'b1; bus.fill_addr_i = mk(25'h77, 3'd2); bus.fill_way_i = 2'd1;
      bus.lookup_valid_i = 1'b1; bus.lookup_addr_i = mk(25'h45, 3'd5);
      bus.flush_i = (i == 3);
      push($sformatf("busy_%0d", i), 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    bus.fill_en_i = 1'b0; bus.lookup_valid_i = 1'b0; bus.flush_i = 1'b0;
    look(mk(25'h45, 3'd5), 1'b0, "flush_done", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b0);
    for (int s = 0; s < 8; s++)
      look(mk(25'h40 + 25'(s), 3'(s)), 1'b0, $sformatf("post_flush_set%0d", s),
           1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b0);
    look(mk(25'h77, 3'd2), 1'b0, "fill_in_busy", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b0);

    // Reset in the third flush cycle: everything returns to the reset state.
    do_fill(mk(25'h33, 3'd3), 2'd0);
    do_fill(mk(25'h66, 3'd6), 2'd1);
    bus.flush_i = 1'b1;
    cyc();
    bus.flush_i = 1'b0;
    bus.lookup_addr_i = mk(25'h66, 3'd6);
    for (int i = 1; i <= 2; i++) begin
      push($sformatf("rflush_%0d", i), 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b0, 1'b0);
      cyc();
    end
    rsn = 1'b0;
    look(mk(25'h66, 3'd6), 1'b0, "reset_mid_flush", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);
    rsn = 1'b1;
    look(mk(25'h66, 3'd6), 1'b0, "rst_set6", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);
    look(mk(25'h33, 3'd3), 1'b0, "rst_set3", 1'b0, 2'd0, 2'd0, 1'b0, 25'h0, 1'b1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
